mult_booth_arb: RTL and testbench
=================================

# mult_booth_arb

Round-robin arbiter that shares one `mult_booth_sync` instance (signed radix-2 Booth multiplier with registered operands and product) between `NUM_REQ` requesters. Each requester gets a valid/ready request channel and a private result register with its own valid/ready return channel. It sits between the accelerator's operand producers and the single shared multiplier, and tracks which requester owns each in-flight product.

## Interface
- `DATA_WIDTH`, 16: operand width; product is `2*DATA_WIDTH`, signed two's complement.
- `NUM_REQ`, 4: number of requesters, 2..16. Tag width `ID_W = $clog2(NUM_REQ)`.
- `i_clk`, in, 1: single clock. All logic is on the rising edge.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `iv_req_valid`, in, `NUM_REQ`: per-requester request valid.
- `ov_req_ready`, out, `NUM_REQ`: per-requester accept (one-hot or zero).
- `iv_req_a`, in, `NUM_REQ*DATA_WIDTH`: operand A, requester i at slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `iv_req_b`, in, `NUM_REQ*DATA_WIDTH`: operand B, same packing.
- `ov_res_valid`, out, `NUM_REQ`: per-requester result pending.
- `iv_res_ready`, in, `NUM_REQ`: per-requester result consume.
- `ov_res_prod`, out, `NUM_REQ*2*DATA_WIDTH`: per-requester product register, slice `[i*2*DATA_WIDTH +: 2*DATA_WIDTH]`.
- `o_busy`, out, 1: high when any op is in flight or any result is pending.

## Operation
- **Shared multiplier.** `mult_booth_sync` is instantiated internally.
  - `i_en` is tied to 1.
  - `i_rst` is tied to `~i_rst_n`; the multiplier's contents are don't-care after reset because the tags are cleared.
  - `iv_a` and `iv_b` are driven combinationally from the granted requester's operand slices, and are 0 when there is no grant.
- **`busy[i]` register.** Set on accept for requester i. Cleared on the edge where `ov_res_valid[i] & iv_res_ready[i]`. At most one op per requester is outstanding.
- **Eligibility.** Requester i is eligible when `iv_req_valid[i] & ~busy[i]`. Eligibility uses the registered `busy`, so a requester whose result is consumed at edge E can be granted in the cycle after E, not in the same cycle.
- **Grant.**
  - Combinational, at most one grant per cycle.
  - Search starts at pointer `rr_ptr` and wraps modulo `NUM_REQ`; the first eligible requester wins.
  - `ov_req_ready = grant`. Accept means `iv_req_valid[i] & ov_req_ready[i]`.
  - On accept, `rr_ptr <= (granted_id + 1) mod NUM_REQ`. With no accept, `rr_ptr` holds.
  - Wrap case: a grant to `NUM_REQ-1` sets `rr_ptr` to 0.
- **Requester rule.** A requester must hold valid and operands stable until accepted. It must not derive valid from ready.
- **Tag pipeline.** Two stages of {valid, id}, matching the multiplier's two register stages.
  - Stage 1 captures {accept, granted_id}.
  - Stage 2 captures stage 1.
  - When stage 2 is valid, the product from the multiplier (`ov_prod`) is written into `ov_res_prod[id]` and `ov_res_valid[id]` is set.
- **Result hold.** `ov_res_valid[i]` holds until consumed. `ov_res_prod[i]` holds its value until the next write to requester i.
- **No collision.** A stage-2 write to requester i cannot coincide with a pending result for i, because `busy[i]` guarantees exclusivity.
- **Reset values.** On assertion, independent of clock:
  - `busy`, both tag stages, `ov_res_valid` and `rr_ptr` reset to 0.
  - `ov_res_prod` resets to 0.
  - In-flight ops are discarded; no results appear after reset.
  - `ov_req_ready` is 0 while `i_rst_n` is low.

## Timing
- **Accept in cycle t:**
  - The multiplier captures the operands at the end of t.
  - The product is registered at the end of t+1.
  - The result register is written at the end of t+2.
  - `ov_res_valid[i]` is high from cycle t+3.
- **Throughput.** One accept per cycle aggregate, for up to `NUM_REQ` distinct requesters back-to-back. A single requester can reissue no earlier than one cycle after its result handshake, so its minimum period is 4 cycles with `iv_res_ready` held high.
- **`ov_req_ready` timing.** Depends combinationally on `iv_req_valid` and registered state only. There is no path from `iv_res_ready` to `ov_req_ready`.
- **`o_busy`** is registered-state OR: `|busy`.

## Configuration
- **`MULT_BOOTH_ARB_FIXED_PRIO_EN` defined:** fixed priority. The lowest-index eligible requester always wins, and `rr_ptr` and its logic are compiled out.
- **Undefined (default):** round-robin as specified above.

## Test plan
- **Single op:** requester 0 presents a=3, b=5 at cycle t.
  - Expect `ov_req_ready[0]=1` at t.
  - Expect `ov_res_valid[0]=1` from t+3 with `ov_res_prod[0]=0x0000000F`.
  - With `iv_res_ready[0]=0` the result holds; when it is raised, valid clears on the next edge.
- **Signed:** requester 2 presents a=0xFFFD (-3), b=0x0005. Expect `ov_res_prod[2]=0xFFFFFFF1`.
  - a=0x8000, b=0x8000 gives 0x40000000.
- **Round-robin fairness:** all 4 valid continuously from reset, with `iv_res_ready` all high.
  - Expect grants in order 0,1,2,3 on consecutive cycles, then 0 again once `busy[0]` has cleared.
  - With the macro defined, expect grants 0,1,2,3 followed by 0 whenever 0 is eligible, even if higher indices are waiting.
- **Backpressure:** requester 1's result is left unconsumed while it keeps valid asserted.
  - Expect `ov_req_ready[1]=0` until one cycle after its result handshake.
  - Other requesters continue to be granted meanwhile.
- **Reset mid-operation:** accept ops for requesters 0 and 1, then pulse `i_rst_n` low asynchronously between clock edges one cycle later.
  - Expect `ov_res_valid`, `o_busy` and `ov_req_ready` to go to 0 immediately.
  - Expect no result to appear after release.
  - The first grant after release goes to requester 0.
- **Wrap-around:** with only requesters 3 and 0 valid and `rr_ptr` at 3, expect grant 3, then 0, with products routed to the correct slices.

Source files
------------

// File: rtl/mult_booth_arb.sv
// Round-robin arbiter sharing one signed radix-2 Booth multiplier among NUM_REQ requesters.
// Define MULT_BOOTH_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.

module mult_booth_sync #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [DATA_WIDTH-1:0]   iv_a,
  input  logic [DATA_WIDTH-1:0]   iv_b,
  output logic [2*DATA_WIDTH-1:0] ov_prod
);
  logic [DATA_WIDTH-1:0]   a_r, b_r;
  logic [2*DATA_WIDTH-1:0] a_ext, acc;
  logic [DATA_WIDTH:0]     b_ext;

  // Booth recoding of {b[i], b[i-1]}: 01 adds, 10 subtracts the shifted multiplicand.
  always_comb begin
    a_ext = {{DATA_WIDTH{a_r[DATA_WIDTH-1]}}, a_r};
    b_ext = {b_r, 1'b0};
    acc   = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      case (b_ext[i +: 2])
        2'b01:   acc = acc + (a_ext << i);
        2'b10:   acc = acc - (a_ext << i);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_r     <= '0;
      b_r     <= '0;
      ov_prod <= '0;
    end else if (i_en) begin
      a_r     <= iv_a;
      b_r     <= iv_b;
      ov_prod <= acc;
    end
  end
endmodule

module mult_booth_arb #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_REQ-1:0]                iv_req_valid,
  output logic [NUM_REQ-1:0]                ov_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     iv_req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     iv_req_b,
  output logic [NUM_REQ-1:0]                ov_res_valid,
  input  logic [NUM_REQ-1:0]                iv_res_ready,
  output logic [NUM_REQ*2*DATA_WIDTH-1:0]   ov_res_prod,
  output logic                              o_busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PW   = 2 * DATA_WIDTH;

  logic [NUM_REQ-1:0]      busy, elig, grant, done, res_set, res_valid;
  logic [ID_W-1:0]         gnt_id, s1_id, s2_id;
  logic                    gnt_any, s1_vld, s2_vld;
  logic [DATA_WIDTH-1:0]   op_a, op_b;
  logic [PW-1:0]           prod;
  logic [NUM_REQ*PW-1:0]   res_prod;

  assign elig = iv_req_valid & ~busy;
  assign done = res_valid & iv_res_ready;

`ifndef MULT_BOOTH_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_ptr;
`endif

  // Scan from highest search offset down so the first eligible in search order wins.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef MULT_BOOTH_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
      if (elig[idx]) begin
        gnt_id  = ID_W'(idx);
        gnt_any = 1'b1;
      end
    end
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

  assign ov_req_ready = grant & {NUM_REQ{i_rst_n}};
  assign op_a = gnt_any ? iv_req_a[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign op_b = gnt_any ? iv_req_b[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH] : '0;

  mult_booth_sync #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
    .i_clk   (i_clk),
    .i_rst   (~i_rst_n),
    .i_en    (1'b1),
    .iv_a    (op_a),
    .iv_b    (op_b),
    .ov_prod (prod)
  );

`ifndef MULT_BOOTH_ARB_FIXED_PRIO_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end
`endif

  always_comb begin
    res_set = '0;
    if (s2_vld) res_set[s2_id] = 1'b1;
  end

  // Tag stages track the multiplier's operand and product registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy      <= '0;
      s1_vld    <= 1'b0;
      s1_id     <= '0;
      s2_vld    <= 1'b0;
      s2_id     <= '0;
      res_valid <= '0;
      res_prod  <= '0;
    end else begin
      busy      <= (busy & ~done) | grant;
      s1_vld    <= gnt_any;
      s1_id     <= gnt_id;
      s2_vld    <= s1_vld;
      s2_id     <= s1_id;
      res_valid <= res_set | (res_valid & ~done);
      if (s2_vld) res_prod[int'(s2_id)*PW +: PW] <= prod;
    end
  end

  assign ov_res_valid = res_valid;
  assign ov_res_prod  = res_prod;
  assign o_busy       = |busy;
endmodule

// File: tb/tb_mult_booth_arb.sv
// Bench for mult_booth_arb: directed vectors and corner sequences plus random traffic,
// all cross-checked every cycle against a transaction-level reference model.

module tb_mult_booth_arb;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int PW = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [N-1:0]    req_valid, req_ready, res_valid, res_ready;
  logic [N*W-1:0]  req_a, req_b;
  logic [N*PW-1:0] res_prod;
  logic            busy;

  always #5 i_clk = ~i_clk;

  mult_booth_arb #(.DATA_WIDTH(W), .NUM_REQ(N)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .iv_req_valid (req_valid),
    .ov_req_ready (req_ready),
    .iv_req_a     (req_a),
    .iv_req_b     (req_b),
    .ov_res_valid (res_valid),
    .iv_res_ready (res_ready),
    .ov_res_prod  (res_prod),
    .o_busy       (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-requester state, results due three cycles after acceptance.
  bit          m_busy[N];
  bit          m_val[N];
  logic [31:0] m_prod[N];
  logic [31:0] m_new[N];
  int          m_due[N];
  int          m_ptr;
  int          cyc_n = 0;
  logic [N-1:0] last_ready;

  function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  function automatic int exp_grant();
    int j;
    for (int k = 0; k < N; k++) begin
`ifdef MULT_BOOTH_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (m_ptr + k) % N;
`endif
      if (req_valid[j] && !m_busy[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_val[i] = 0; m_prod[i] = '0; m_new[i] = '0; m_due[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic cycle();
    int g;
    logic [N-1:0] one, exp_rdy, exp_v;
    logic exp_b;
    @(negedge i_clk);
    one = 1;
    g = exp_grant();
    exp_rdy = (g >= 0) ? (one << g) : '0;
    exp_v = '0;
    exp_b = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_v[i] = m_val[i];
      exp_b |= m_busy[i];
      chk("res_prod", 128'(res_prod[i*PW +: PW]), 128'(m_prod[i]));
    end
    chk("req_ready", 128'(req_ready), 128'(exp_rdy));
    chk("res_valid", 128'(res_valid), 128'(exp_v));
    chk("o_busy", 128'(busy), 128'(exp_b));
    last_ready = req_ready;
    if (g >= 0) begin
      m_busy[g] = 1;
      m_due[g]  = cyc_n + 3;
      m_new[g]  = smul(req_a[g*W +: W], req_b[g*W +: W]);
      m_ptr     = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (m_val[i] && res_ready[i]) begin
        m_val[i] = 0; m_busy[i] = 0;
      end
      if (m_busy[i] && !m_val[i] && m_due[i] == cyc_n + 1) begin
        m_val[i] = 1; m_prod[i] = m_new[i];
      end
    end
    cyc_n++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_op(input int i);
    req_a[i*W +: W] = 16'($urandom);
    req_b[i*W +: W] = 16'($urandom);
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [N-1:0] one;
    int gr1, gro;
    one = 1;
    vecs[0] = '{0, 16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{2, 16'hFFFD, 16'h0005, 32'hFFFFFFF1};
    vecs[2] = '{1, 16'h8000, 16'h8000, 32'h40000000};
    vecs[3] = '{3, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[4] = '{0, 16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[5] = '{1, 16'h8000, 16'h7FFF, 32'hC0008000};
    vecs[6] = '{2, 16'h0000, 16'h1234, 32'h00000000};

    i_rst_n = 1'b0;
    req_valid = '1; req_a = '0; req_b = '0; res_ready = '0;
    model_reset();
    #12;
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_prod", 128'(res_prod), 128'(0));
    req_valid = '0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed single ops with result hold and handshake.
    for (int v = 0; v < 7; v++) begin
      req_valid = one << vecs[v].id;
      req_a[vecs[v].id*W +: W] = vecs[v].a;
      req_b[vecs[v].id*W +: W] = vecs[v].b;
      #1 chk("vec_ready", 128'(req_ready), 128'(one << vecs[v].id));
      cycle();
      req_valid = '0;
      cycle();
      cycle();
      chk("vec_valid", 128'(res_valid), 128'(one << vecs[v].id));
      chk("vec_prod", 128'(res_prod[vecs[v].id*PW +: PW]), 128'(vecs[v].p));
      cycle();
      chk("vec_hold", 128'(res_valid), 128'(one << vecs[v].id));
      res_ready = one << vecs[v].id;
      cycle();
      chk("vec_consumed", 128'(res_valid), 128'(0));
      chk("vec_prod_kept", 128'(res_prod[vecs[v].id*PW +: PW]), 128'(vecs[v].p));
      res_ready = '0;
    end

    // Reset in the middle of two in-flight ops.
    req_valid = 4'b0011; set_op(0); set_op(1);
    cycle();
    cycle();
    #1 i_rst_n = 1'b0;
    #1 model_reset();
    chk("mid_rst_valid", 128'(res_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_ready", 128'(req_ready), 128'(0));
    i_rst_n = 1'b1;
    #1 chk("post_rst_grant", 128'(req_ready), 128'(4'b0001));
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("post_rst_no_result", 128'(res_valid), 128'(0));
    end

    // Fairness: all requesters continuously valid, results consumed at once.
    res_ready = '1;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_op(i);
    for (int k = 0; k < 12; k++) begin
      #1 chk("rr_order", 128'(req_ready), 128'(one << (k % 4)));
      cycle();
      for (int i = 0; i < N; i++) if (last_ready[i]) set_op(i);
    end
    req_valid = '0;
    repeat (6) cycle();

    // Backpressure on requester 1.
    res_ready = 4'b1101;
    req_valid = '1;
    gr1 = 0; gro = 0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      for (int i = 0; i < N; i++) if (last_ready[i]) begin
        set_op(i);
        if (i == 1) gr1++; else gro++;
      end
    end
    chk("bp_grants_req1", 128'(gr1), 128'(1));
    chk("bp_others_progress", 128'(gro >= 4), 128'(1));
    res_ready = '1;
    repeat (4) cycle();
    req_valid = '0;
    repeat (6) cycle();

    // Wrap-around: park the pointer at 3, then requesters 3 and 0 together.
    req_valid = 4'b0100; set_op(2);
    cycle();
    req_valid = '0;
    repeat (5) cycle();
    req_valid = 4'b1001; set_op(0); set_op(3);
`ifdef MULT_BOOTH_ARB_FIXED_PRIO_EN
    #1 chk("wrap_first", 128'(req_ready), 128'(4'b0001));
    cycle();
    req_valid = 4'b1000;
    #1 chk("wrap_second", 128'(req_ready), 128'(4'b1000));
`else
    #1 chk("wrap_first", 128'(req_ready), 128'(4'b1000));
    cycle();
    req_valid = 4'b0001;
    #1 chk("wrap_second", 128'(req_ready), 128'(4'b0001));
`endif
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("wrap_prod0", 128'(res_prod[0*PW +: PW]), 128'(smul(req_a[0*W +: W], req_b[0*W +: W])));
    chk("wrap_prod3", 128'(res_prod[3*PW +: PW]), 128'(smul(req_a[3*W +: W], req_b[3*W +: W])));

    // Random traffic; requesters hold valid and operands until accepted.
    last_ready = '0;
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_ready[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_op(i);
        end
      end
      res_ready = 4'($urandom);
      cycle();
    end
    req_valid = '0;
    res_ready = '1;
    repeat (8) cycle();
    chk("final_idle", 128'(busy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
